// File: rtl/aes_stream_ctrl_pkg.sv
// Shared types and constants for the AES streaming controller.
package aes_package;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ_SRC,
        WAIT_SRC,
        RUN,
        REQ_SNK,
        WAIT_SNK,
        FINISH
    } aes_stream_state_t;

endpackage

// File: rtl/aes_stream_ctrl_addr_gen.sv
// Block address generator: base + index*stride, wrapping modulo 2^ADDR_W.
module aes_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 16,
    parameter int STRIDE = 16
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [IDX_W-1:0]  index_i,
    output logic [ADDR_W-1:0] addr_o
);

    // STRIDE is a power of two, so the multiply reduces to a shift.
    localparam int SHIFT = $clog2(STRIDE);

    logic [ADDR_W-1:0] idx_ext;

    assign idx_ext = ADDR_W'(index_i);
    assign addr_o  = base_i + (idx_ext << SHIFT);

endmodule

// File: rtl/aes_stream_ctrl.sv
// Job sequencer: streams n_blocks AES blocks source -> engine -> sink.
module aes_stream_ctrl
    import aes_package::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int BLOCK_BYTES = AES_BLOCK_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_blocks_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    output logic              src_req_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic              src_ready_i,
    input  logic              src_done_i,
    output logic              eng_start_o,
    output logic              eng_mode_o,
    input  logic              eng_done_i,
    output logic              snk_req_o,
    output logic [ADDR_W-1:0] snk_addr_o,
    input  logic              snk_ready_i,
    input  logic              snk_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);

    aes_stream_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            mode_q     <= 1'b0;
            src_base_q <= '0;
            dst_base_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
        end
    end

    // Request/strobe outputs decode state_q only, keeping inputs off the req paths.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        mode_d      = mode_q;
        src_base_d  = src_base_q;
        dst_base_d  = dst_base_q;
        src_req_o   = 1'b0;
        snk_req_o   = 1'b0;
        eng_start_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_d        = n_blocks_i;
                    mode_d     = mode_i;
                    src_base_d = src_base_i;
                    dst_base_d = dst_base_i;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                eng_start_o = 1'b1;
                cnt_d       = '0;
                state_d     = (n_q == '0) ? FINISH : REQ_SRC;
            end
            REQ_SRC: begin
                src_req_o = 1'b1;
                if (src_ready_i) state_d = WAIT_SRC;
            end
            WAIT_SRC: begin
                if (src_done_i) state_d = RUN;
            end
            RUN: begin
                if (eng_done_i) state_d = REQ_SNK;
            end
            REQ_SNK: begin
                snk_req_o = 1'b1;
                if (snk_ready_i) state_d = WAIT_SNK;
            end
            WAIT_SNK: begin
                if (snk_done_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == n_q) ? FINISH : REQ_SRC;
                end
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign eng_mode_o = mode_q;
    assign blk_cnt_o  = cnt_q;

    aes_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (CNT_W),
        .STRIDE (BLOCK_BYTES)
    ) u_src_addr (
        .base_i  (src_base_q),
        .index_i (cnt_q),
        .addr_o  (src_addr_o)
    );

    aes_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (CNT_W),
        .STRIDE (BLOCK_BYTES)
    ) u_snk_addr (
        .base_i  (dst_base_q),
        .index_i (cnt_q),
        .addr_o  (snk_addr_o)
    );

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Randomized bench for aes_stream_ctrl: drives streamer/engine responders
// and checks addresses, strobes and status against an arithmetic job model.
module tb_aes_stream_ctrl;

    localparam int AW = 32;
    localparam int CW = 5;
    localparam int BB = 16;

    logic          clk = 1'b0;
    logic          reset, clear, start_i, mode_i;
    logic [CW-1:0] n_blocks_i;
    logic [AW-1:0] src_base_i, dst_base_i;
    logic          src_req_o, src_ready_i, src_done_i;
    logic [AW-1:0] src_addr_o, snk_addr_o;
    logic          eng_start_o, eng_mode_o, eng_done_i;
    logic          snk_req_o, snk_ready_i, snk_done_i;
    logic          busy_o, done_o;
    logic [CW-1:0] blk_cnt_o;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int src_req_seen = 0;
    int snk_req_seen = 0;
    int max_lat = 3;

    aes_stream_ctrl #(.ADDR_W(AW), .CNT_W(CW), .BLOCK_BYTES(BB)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .start_i     (start_i),
        .n_blocks_i  (n_blocks_i),
        .mode_i      (mode_i),
        .src_base_i  (src_base_i),
        .dst_base_i  (dst_base_i),
        .src_req_o   (src_req_o),
        .src_addr_o  (src_addr_o),
        .src_ready_i (src_ready_i),
        .src_done_i  (src_done_i),
        .eng_start_o (eng_start_o),
        .eng_mode_o  (eng_mode_o),
        .eng_done_i  (eng_done_i),
        .snk_req_o   (snk_req_o),
        .snk_addr_o  (snk_addr_o),
        .snk_ready_i (snk_ready_i),
        .snk_done_i  (snk_done_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .blk_cnt_o   (blk_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o)    done_seen++;
        if (src_req_o) src_req_seen++;
        if (snk_req_o) snk_req_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_req(input bit snk);
        int t = 0;
        while (((snk ? snk_req_o : src_req_o) !== 1'b1) && t < 40) begin
            tick();
            t++;
        end
        chk(snk ? "snk_req_wait" : "src_req_wait", snk ? snk_req_o : src_req_o, 1);
    endtask

    // One streamer transfer: request, hold-off, ready, then done after a delay.
    task automatic xfer(input bit snk, input logic [AW-1:0] exp_addr, input int hold);
        logic [AW-1:0] a0;
        int h;
        h = (hold < 0) ? $urandom_range(0, max_lat) : hold;
        wait_req(snk);
        a0 = snk ? snk_addr_o : src_addr_o;
        chk(snk ? "snk_addr" : "src_addr", a0, exp_addr);
        for (int i = 0; i < h; i++) begin
            eng_done_i = 1'($urandom_range(0, 1));
            if (snk) src_done_i = 1'($urandom_range(0, 1));
            else     snk_done_i = 1'($urandom_range(0, 1));
            tick();
            chk("req_hold", snk ? snk_req_o : src_req_o, 1);
            chk("addr_stable", snk ? snk_addr_o : src_addr_o, a0);
        end
        eng_done_i = 1'b0;
        src_done_i = 1'b0;
        snk_done_i = 1'b0;
        if (snk) snk_ready_i = 1'b1;
        else     src_ready_i = 1'b1;
        tick();
        src_ready_i = 1'b0;
        snk_ready_i = 1'b0;
        chk("req_drop", snk ? snk_req_o : src_req_o, 0);
        repeat ($urandom_range(0, max_lat)) tick();
        if (snk) snk_done_i = 1'b1;
        else     src_done_i = 1'b1;
        tick();
        src_done_i = 1'b0;
        snk_done_i = 1'b0;
    endtask

    task automatic run_job(input logic [CW-1:0] n, input logic [AW-1:0] sb,
                           input logic [AW-1:0] db, input bit md,
                           input int hold, input bit poke);
        int d0;
        d0 = done_seen;
        start_i    = 1'b1;
        n_blocks_i = n;
        src_base_i = sb;
        dst_base_i = db;
        mode_i     = md;
        tick();
        start_i    = 1'b0;
        n_blocks_i = CW'($urandom);
        src_base_i = $urandom;
        dst_base_i = $urandom;
        mode_i     = 1'($urandom_range(0, 1));
        chk("eng_start", eng_start_o, 1);
        chk("busy_load", busy_o, 1);
        tick();
        chk("eng_start_once", eng_start_o, 0);
        for (int k = 0; k < int'(n); k++) begin
            xfer(1'b0, sb + k * BB, hold);
            chk("eng_mode", eng_mode_o, md);
            if (poke && k == 0) begin
                start_i     = 1'b1;
                mode_i      = ~md;
                n_blocks_i  = n + CW'(1);
                src_ready_i = 1'b1;
                src_done_i  = 1'b1;
                snk_ready_i = 1'b1;
                snk_done_i  = 1'b1;
                tick();
                start_i     = 1'b0;
                src_ready_i = 1'b0;
                src_done_i  = 1'b0;
                snk_ready_i = 1'b0;
                snk_done_i  = 1'b0;
                chk("eng_mode_poke", eng_mode_o, md);
                chk("snk_req_poke", snk_req_o, 0);
            end
            repeat ($urandom_range(0, max_lat)) tick();
            eng_done_i = 1'b1;
            tick();
            eng_done_i = 1'b0;
            xfer(1'b1, db + k * BB, hold);
        end
        chk("done_pulse", done_o, 1);
        chk("blk_cnt_final", blk_cnt_o, n);
        tick();
        chk("done_clear", done_o, 0);
        chk("busy_idle", busy_o, 0);
        chk("blk_cnt_hold", blk_cnt_o, n);
        tick();
        chk("done_count", done_seen - d0, 1);
    endtask

    initial begin
        int s0, k0;
        reset       = 1'b1;
        clear       = 1'b0;
        start_i     = 1'b0;
        mode_i      = 1'b0;
        n_blocks_i  = '0;
        src_base_i  = '0;
        dst_base_i  = '0;
        src_ready_i = 1'b0;
        src_done_i  = 1'b0;
        eng_done_i  = 1'b0;
        snk_ready_i = 1'b0;
        snk_done_i  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", blk_cnt_o, 0);
        chk("rst_reqs", {src_req_o, snk_req_o, eng_start_o, eng_mode_o}, 0);
        chk("rst_addrs", {src_addr_o, snk_addr_o}, 0);

        // Immediate handshakes, three blocks.
        max_lat = 0;
        run_job(3, 32'h1000, 32'h2000, 1'b0, -1, 1'b0);

        // Empty job: engine start and done only.
        s0 = src_req_seen;
        k0 = snk_req_seen;
        run_job(0, 32'h5000, 32'h6000, 1'b1, -1, 1'b0);
        chk("n0_no_src_req", src_req_seen - s0, 0);
        chk("n0_no_snk_req", snk_req_seen - k0, 0);

        // Long ready hold-off.
        max_lat = 3;
        run_job(2, 32'h0000_8000, 32'h0000_9000, 1'b1, 10, 1'b0);

        // Address wrap.
        run_job(2, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 1'b0, -1, 1'b0);

        // Start pulsed mid-job with the opposite mode.
        run_job(3, 32'h0001_0000, 32'h0002_0000, 1'b0, -1, 1'b1);

        // Clear during RUN of block 1 of 4.
        start_i    = 1'b1;
        n_blocks_i = 4;
        src_base_i = 32'h3000;
        dst_base_i = 32'h4000;
        mode_i     = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        xfer(1'b0, 32'h3000, -1);
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        xfer(1'b1, 32'h4000, -1);
        xfer(1'b0, 32'h3010, -1);
        chk("pre_clear_cnt", blk_cnt_o, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", busy_o, 0);
        chk("clr_cnt", blk_cnt_o, 0);
        chk("clr_mode", eng_mode_o, 0);
        chk("clr_addrs", {src_addr_o, snk_addr_o}, 0);

        // Clear wins over a simultaneous start.
        clear   = 1'b1;
        start_i = 1'b1;
        tick();
        clear   = 1'b0;
        start_i = 1'b0;
        tick();
        chk("clr_start_prio", busy_o, 0);
        run_job(4, 32'h3000, 32'h4000, 1'b0, -1, 1'b0);

        // Full-scale block count without wrap.
        run_job(5'd31, $urandom, $urandom, 1'b1, -1, 1'b0);

        for (int j = 0; j < 6; j++) begin
            run_job(CW'($urandom_range(1, 6)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter CNT_W, default 16: block-count width.
REQ-003 Parameter BLOCK_BYTES, default 16: address stride per block; must be a power of two.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clear  in  1  synchronous soft clear; same effect as reset.
REQ-007 start_i  in  1  job start pulse from the slave regfile.
REQ-008 n_blocks_i  in  CNT_W  number of 128-bit blocks in the job.
REQ-009 mode_i  in  1  0 = encrypt, 1 = decrypt.
REQ-010 src_base_i / dst_base_i  in  ADDR_W each  plaintext source and ciphertext sink base addresses.
REQ-011 src_req_o  out  1; src_addr_o  out  ADDR_W; src_ready_i  in  1; src_done_i  in  1  source-streamer handshake.
REQ-012 eng_start_o  out  1; eng_mode_o  out  1; eng_done_i  in  1  engine handshake.
REQ-013 snk_req_o  out  1; snk_addr_o  out  ADDR_W; snk_ready_i  in  1; snk_done_i  in  1  sink-streamer handshake.
REQ-014 busy_o  out  1; done_o  out  1; blk_cnt_o  out  CNT_W  status to the slave.

Function
REQ-015 States: IDLE, LOAD, REQ_SRC, WAIT_SRC, RUN, REQ_SNK, WAIT_SNK, FINISH.
REQ-016 IDLE: on start_i, capture n_blocks_i, mode_i and both bases, then go to LOAD; start_i in any other state is ignored.
REQ-017 LOAD: assert eng_start_o for one cycle and clear blk_cnt to 0. Next state is REQ_SRC, or FINISH if the captured n_blocks is 0.
REQ-018 REQ_SRC: hold src_req_o high until src_ready_i is sampled high, then go to WAIT_SRC; the req is deasserted in the cycle after ready.
REQ-019 WAIT_SRC: on src_done_i go to RUN.
REQ-020 RUN: wait for eng_done_i, then go to REQ_SNK.
REQ-021 REQ_SNK/WAIT_SNK: mirror REQ-018/019 using the snk_* signals.
REQ-022 On snk_done_i, blk_cnt increments.
REQ-023 After that increment, if the new blk_cnt equals n_blocks go to FINISH, else go to REQ_SRC.
REQ-024 src_addr_o = src_base + blk_cnt*BLOCK_BYTES and snk_addr_o = dst_base + blk_cnt*BLOCK_BYTES, both truncated modulo 2^ADDR_W, combinational from registered values.
REQ-025 Address outputs are valid whenever the matching req is high.
REQ-026 eng_mode_o equals the captured mode for the whole job.
REQ-027 FINISH: done_o high for exactly one cycle, then IDLE.
REQ-028 busy_o is high in every state except IDLE.
REQ-029 blk_cnt_o holds its final value in IDLE until the next start.
REQ-030 Done/ready inputs arriving in a state that does not expect them are ignored.
REQ-031 n_blocks = 2^CNT_W-1 runs to completion without counter wrap.
REQ-032 No combinational path from any *_i input to any req output.

Reset
REQ-033 reset or clear, mid-job or otherwise, forces IDLE at the next edge.
REQ-034 reset or clear drives blk_cnt and all captured registers to 0.
REQ-035 On reset or clear, every output is 0 from the following cycle, including addresses (base 0).
REQ-036 clear has priority over start_i in the same cycle.

Structure
REQ-037 The state enum aes_stream_state_t goes in aes_package.
REQ-038 The AES block size constant AES_BLOCK_BYTES = 16 goes in aes_package.
REQ-039 One sub-module, aes_addr_gen, computes base + index*stride; it is instantiated twice (src, snk).
REQ-040 The FSM and counter live in aes_stream_ctrl.

Verification
REQ-041 n_blocks=3, src_base=0x1000, dst_base=0x2000, immediate readies/dones:
- src_addr sequence must be 0x1000/0x1010/0x1020;
- snk_addr sequence must be 0x2000/0x2010/0x2020;
- exactly one done_o pulse; blk_cnt_o=3.
REQ-042 n_blocks=0 -> must see eng_start_o pulse and done_o two cycles after start, with no src_req_o or snk_req_o.
REQ-043 src_ready_i held low 10 cycles -> src_req_o must stay high for all 10 cycles; src_addr_o stable throughout.
REQ-044 clear asserted during RUN of block 1 of 4 -> next cycle busy_o=0 and blk_cnt_o=0; a new start runs cleanly from 0.
REQ-045 src_base=0xFFFFFFF0, n_blocks=2 -> second src_addr_o must be 0x00000000 (wrap).
REQ-046 start_i pulsed mid-job with mode_i=1 while running mode 0 -> eng_mode_o must stay 0; job completes unchanged.
